// File: rtl/alu_pkg.sv
// Shared opcode, state and helper definitions for the serial ALU engine and its 1-bit slice.
package alu_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic is_supported(input logic [3:0] op);
      return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
             (op == OP_SUB) || (op == OP_SLT) || (op == OP_NOR);
   endfunction

   // SUB and SLT both run as A + ~B + 1
   function automatic logic is_sub(input logic [3:0] op);
      return (op == OP_SUB) || (op == OP_SLT);
   endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice; subtraction-type opcodes arrive with b already inverted.
module alu_bit_slice
   import alu_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic [3:0] op,
   output logic       r,
   output logic       cout
);

   always_comb begin
      r    = 1'b0;
      cout = 1'b0;
      case (op)
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_NOR: r = ~(a | b);
         OP_ADD, OP_SUB, OP_SLT: begin
            r    = a ^ b ^ cin;
            cout = (a & b) | (cin & (a ^ b));
         end
         default: begin
            r    = 1'b0;
            cout = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/serial_alu_engine.sv
// Bit-serial N-bit ALU: latches an operand pair, runs one slice per clock LSB first,
// and returns result plus flags over a valid/ready handshake.
module serial_alu_engine
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             err
);

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, sh_q;
   logic [3:0]       op_q;
   logic             cy_q;
   logic [CNT_W-1:0] cnt_q;
   logic             in_ready_q, out_valid_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_q, overflow_q, zero_q, err_q;

   logic             slice_b, slice_r, slice_cout, ovf_raw;
   logic [WIDTH-1:0] result_d;
   logic             carry_d, overflow_d;

   assign slice_b = b_q[0] ^ is_sub(op_q);

   alu_bit_slice u_slice (
      .a    (a_q[0]),
      .b    (slice_b),
      .cin  (cy_q),
      .op   (op_q),
      .r    (slice_r),
      .cout (slice_cout)
   );

   // Only meaningful on the MSB cycle, where cy_q is the MSB carry-in
   assign ovf_raw = cy_q ^ slice_cout;

   always_comb begin
      result_d   = {slice_r, sh_q[WIDTH-1:1]};
      carry_d    = 1'b0;
      overflow_d = 1'b0;
      case (op_q)
         OP_ADD, OP_SUB: begin
            carry_d    = slice_cout;
            overflow_d = ovf_raw;
         end
         OP_SLT: begin
            result_d = WIDTH'(slice_r ^ ovf_raw);
            carry_d  = slice_cout;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      case (state_q)
         ST_IDLE: if (in_valid) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= alu_op;
            cy_q <= is_sub(alu_op);
         end
         ST_RUN: begin
            a_q  <= a_q >> 1;
            b_q  <= b_q >> 1;
            sh_q <= result_d;
            cy_q <= slice_cout;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         overflow_q  <= 1'b0;
         zero_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (in_valid && in_ready_q) begin
               in_ready_q <= 1'b0;
               cnt_q      <= '0;
               if (is_supported(alu_op)) begin
                  state_q <= ST_RUN;
               end else begin
                  state_q     <= ST_DONE;
                  out_valid_q <= 1'b1;
                  result_q    <= '0;
                  carry_q     <= 1'b0;
                  overflow_q  <= 1'b0;
                  zero_q      <= 1'b1;
                  err_q       <= 1'b1;
               end
            end
            ST_RUN: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_q     <= ST_DONE;
                  out_valid_q <= 1'b1;
                  result_q    <= result_d;
                  carry_q     <= carry_d;
                  overflow_q  <= overflow_d;
                  zero_q      <= (result_d == '0);
                  err_q       <= 1'b0;
               end
            end
            ST_DONE: if (out_ready) begin
               state_q     <= ST_IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign carry     = carry_q;
   assign overflow  = overflow_q;
   assign zero      = zero_q;
   assign err       = err_q;

endmodule

// File: tb/tb_serial_alu_engine.sv
// Directed bench for serial_alu_engine (WIDTH=8) with hand-computed expected values.
module tb_serial_alu_engine;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a, b;
   logic [3:0]       alu_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry, overflow, zero, err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_alu_engine #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .alu_op    (alu_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .overflow  (overflow),
      .zero      (zero),
      .err       (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Offer one operation, return the number of clock edges after the accept edge
   // until out_valid is seen (WIDTH for a normal op, 0 for an unsupported opcode).
   task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [3:0] iop,
                        output int lat);
      @(negedge clk);
      check("in_ready_before_accept", 32'(in_ready), 32'd1);
      a = ia; b = ib; alu_op = iop; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
   endtask

   task automatic release_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("out_valid_drop", 32'(out_valid), 32'd0);
      check("in_ready_back", 32'(in_ready), 32'd1);
   endtask

   task automatic expect_out(input string tag, input logic [7:0] r, input logic c,
                             input logic v, input logic z, input logic e);
      check({tag, "_result"},   32'(result),   32'(r));
      check({tag, "_carry"},    32'(carry),    32'(c));
      check({tag, "_overflow"}, 32'(overflow), 32'(v));
      check({tag, "_zero"},     32'(zero),     32'(z));
      check({tag, "_err"},      32'(err),      32'(e));
   endtask

   initial begin
      int lat;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; alu_op = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      expect_out("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Test 1: signed overflow on ADD
      issue(8'h7F, 8'h01, 4'b0010, lat);
      check("add_latency", 32'(lat), 32'(WIDTH));
      check("add_in_ready_done", 32'(in_ready), 32'd0);
      expect_out("add", 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
      release_result();

      // Test 2: SUB with borrow, then equal operands
      issue(8'h05, 8'h07, 4'b0110, lat);
      check("sub1_latency", 32'(lat), 32'(WIDTH));
      expect_out("sub1", 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
      release_result();
      issue(8'h07, 8'h07, 4'b0110, lat);
      expect_out("sub2", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      release_result();

      // Test 3: SLT both directions with overflowing subtraction
      issue(8'h80, 8'h01, 4'b0111, lat);
      expect_out("slt1", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
      release_result();
      issue(8'h01, 8'h80, 4'b0111, lat);
      expect_out("slt2", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      release_result();

      // Test 4: logical ops
      issue(8'hF0, 8'h3C, 4'b0000, lat);
      expect_out("and", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
      release_result();
      issue(8'hF0, 8'h3C, 4'b0001, lat);
      expect_out("or", 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0);
      release_result();
      issue(8'h00, 8'h00, 4'b1100, lat);
      expect_out("nor", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      release_result();

      // Test 5: unsupported opcode, held under backpressure with an ignored offer
      issue(8'h01, 8'h00, 4'b1111, lat);
      check("err_latency", 32'(lat), 32'd0);
      expect_out("err", 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      a = 8'h11; b = 8'h22; alu_op = 4'b0010; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("hold_out_valid", 32'(out_valid), 32'd1);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         expect_out("hold", 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      release_result();
      @(posedge clk); #1;
      check("ignored_offer_out_valid", 32'(out_valid), 32'd0);

      // Test 6: reset mid-run, then a clean ADD
      @(negedge clk);
      a = 8'hFF; b = 8'h01; alu_op = 4'b0010; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      expect_out("midrst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      issue(8'h03, 8'h04, 4'b0010, lat);
      check("post_rst_latency", 32'(lat), 32'(WIDTH));
      expect_out("post_rst_add", 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
      release_result();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
